// File: rtl/btn_pkg.sv
// Button conditioner shared package.
// Holds the per-channel FSM state encoding and the default parameter values
// used by btn_conditioner and btn_channel.
package btn_pkg;

  // Per-channel state. IDLE means the debounced level is 0. HELD means the
  // level is 1 and the initial repeat delay is counting. REPEATING means the
  // level is 1 and the repeat rate timer is counting.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_HELD      = 2'b01,
    ST_REPEATING = 2'b10
  } btn_state_e;

  localparam int DEF_N_BTN         = 5;
  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY  = 50000000;
  localparam int DEF_REPEAT_RATE   = 10000000;
  localparam int DEF_CNT_W         = 32;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, stability-counter debouncer and
// press/held/repeat FSM.
// Ports:
//   clkin, reset  : rising-edge clock, asynchronous active-high reset
//   btn_in        : raw asynchronous button level (1 = pressed)
//   repeat_en     : auto-repeat enable, sampled every cycle
//   level         : debounced level (registered)
//   pulse_press   : one-cycle pulse when level goes 0->1
//   pulse_release : one-cycle pulse when level goes 1->0
//   pulse_repeat  : one-cycle auto-repeat pulse while held
//   state         : current FSM state (debug visibility)
module btn_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       repeat_en,
  output logic       level,
  output logic       pulse_press,
  output logic       pulse_release,
  output logic       pulse_repeat,
  output btn_state_e state
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_MAX  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_MAX   = CNT_W'(REPEAT_RATE - 1);

  logic [1:0]       sync_q;
  logic             sync_val;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign sync_val = sync_q[1];
  // The synchronised value has differed from the level for STABLE_CYCLES
  // consecutive cycles, counting this one.
  assign accept   = (sync_val != level) && (stab_cnt == STABLE_MAX);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync_q        <= 2'b00;
      stab_cnt      <= '0;
      rep_cnt       <= '0;
      level         <= 1'b0;
      pulse_press   <= 1'b0;
      pulse_release <= 1'b0;
      pulse_repeat  <= 1'b0;
      state         <= ST_IDLE;
    end else begin
      sync_q        <= {sync_q[0], btn_in};
      pulse_press   <= 1'b0;
      pulse_release <= 1'b0;
      pulse_repeat  <= 1'b0;

      // Debounce: any sample matching the current level restarts the count.
      if (sync_val == level) begin
        stab_cnt <= '0;
      end else if (accept) begin
        level    <= sync_val;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= sat_inc(stab_cnt);
      end

      // FSM follows the debounced level; a release is checked before any
      // repeat so the two pulses can never coincide.
      case (state)
        ST_IDLE: begin
          if (accept && sync_val) begin
            state       <= ST_HELD;
            pulse_press <= 1'b1;
            rep_cnt     <= '0;
          end
        end
        ST_HELD: begin
          if (accept && !sync_val) begin
            state         <= ST_IDLE;
            pulse_release <= 1'b1;
            rep_cnt       <= '0;
          end else if (!repeat_en) begin
            rep_cnt <= '0;
          end else if (rep_cnt == DELAY_MAX) begin
            state        <= ST_REPEATING;
            pulse_repeat <= 1'b1;
            rep_cnt      <= '0;
          end else begin
            rep_cnt <= sat_inc(rep_cnt);
          end
        end
        ST_REPEATING: begin
          if (accept && !sync_val) begin
            state         <= ST_IDLE;
            pulse_release <= 1'b1;
            rep_cnt       <= '0;
          end else if (!repeat_en) begin
            // Disabling falls back to HELD so re-enabling restarts the delay.
            state   <= ST_HELD;
            rep_cnt <= '0;
          end else if (rep_cnt == RATE_MAX) begin
            pulse_repeat <= 1'b1;
            rep_cnt      <= '0;
          end else begin
            rep_cnt <= sat_inc(rep_cnt);
          end
        end
        default: begin
          state   <= ST_IDLE;
          rep_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: N_BTN independent btn_channel instances.
// Ports:
//   clkin, reset : rising-edge clock, asynchronous active-high reset
//   btn_in       : raw button levels, 1 = pressed
//   repeat_en    : per-channel auto-repeat enable
//   btn_level    : debounced levels
//   btn_press    : one-cycle pulses on accepted 0->1
//   btn_release  : one-cycle pulses on accepted 1->0
//   btn_repeat   : one-cycle auto-repeat pulses
//   chan_state   : packed per-channel FSM state, 2 bits per channel (debug)
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN         = DEF_N_BTN,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn_in,
  input  logic [N_BTN-1:0]   repeat_en,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_press,
  output logic [N_BTN-1:0]   btn_release,
  output logic [N_BTN-1:0]   btn_repeat,
  output logic [2*N_BTN-1:0] chan_state
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_state_e st;

    btn_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clkin        (clkin),
      .reset        (reset),
      .btn_in       (btn_in[i]),
      .repeat_en    (repeat_en[i]),
      .level        (btn_level[i]),
      .pulse_press  (btn_press[i]),
      .pulse_release(btn_release[i]),
      .pulse_repeat (btn_repeat[i]),
      .state        (st)
    );

    assign chan_state[2*i +: 2] = st;
  end

endmodule
